// File: rtl/pl_mem_access.sv
// MEM-stage load/store unit for a little-endian 32-bit word RAM with synchronous read.
// Word stores finish in one cycle, loads take one stall cycle, sub-word stores read-modify-write.
module pl_mem_access (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, LD, RMW_RD, RMW_WR} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state, state_nxt;
  logic [31:0] cap_addr;
  logic [15:0] cap_wdata;
  logic [1:0]  cap_size;
  logic        cap_sext;
  logic        cap_wr;
  logic [31:0] merged;
  logic        bad_align;

  // Pick the addressed lane out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b   = word[{lane, 3'b000} +: 8];
    h   = word[{lane[1], 4'b0000} +: 16];
    res = word;
    if (sz == SZ_BYTE)      res = {{24{sx & b[7]}}, b};
    else if (sz == SZ_HALF) res = {{16{sx & h[15]}}, h};
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] sz, input logic [15:0] wd);
    logic [31:0] res;
    res = word;
    if (sz == SZ_BYTE) res[{lane, 3'b000} +: 8]     = wd[7:0];
    else               res[{lane[1], 4'b0000} +: 16] = wd;
    return res;
  endfunction

  always_comb begin
    bad_align = 1'b0;
    case (size)
      SZ_HALF: bad_align = addr[0];
      SZ_WORD: bad_align = (addr[1:0] != 2'b00);
      SZ_BYTE: bad_align = 1'b0;
      default: bad_align = 1'b1;
    endcase
  end

  // NOTE: non-blocking assignments in sequential logic so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_size  <= '0;
      cap_sext  <= 1'b0;
      cap_wr    <= 1'b0;
      merged    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        cap_addr  <= addr;
        cap_wdata <= wdata[15:0];
        cap_size  <= size;
        cap_sext  <= sext;
        cap_wr    <= wr;
      end
      if (state == RMW_RD)
        merged <= store_merge(mem_dout, cap_addr[1:0], cap_size, cap_wdata);
    end
  end

  // NOTE: every output and the next state get a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    rdata     = '0;
    stall     = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        mem_addr = {addr[31:2], 2'b00};
        if (req) begin
          if (bad_align) begin
            misalign = 1'b1;
          end else if (wr && size == SZ_WORD) begin
            mem_we  = 1'b1;
            mem_din = wdata;
            done    = 1'b1;
          end else if (!wr) begin
            stall     = 1'b1;
            state_nxt = LD;
          end else begin
            stall     = 1'b1;
            state_nxt = RMW_RD;
          end
        end
      end
      LD: begin
        mem_addr  = {cap_addr[31:2], 2'b00};
        rdata     = load_extract(mem_dout, cap_addr[1:0], cap_size, cap_sext);
        done      = 1'b1;
        state_nxt = IDLE;
      end
      RMW_RD: begin
        mem_addr  = {cap_addr[31:2], 2'b00};
        stall     = 1'b1;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        mem_addr  = {cap_addr[31:2], 2'b00};
        mem_we    = cap_wr;
        mem_din   = merged;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are quiet during reset whatever the inputs do, so an aborted RMW never writes.
    if (!resetn) begin
      rdata    = '0;
      stall    = 1'b0;
      done     = 1'b0;
      misalign = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      mem_we   = 1'b0;
    end
  end

endmodule

// File: tb/tb_pl_mem_access.sv
// Directed bench for pl_mem_access with a small synchronous-read RAM model and
// a scoreboard of expected completions.
module tb_pl_mem_access;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req, wr, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, mem_addr, mem_din, mem_dout;
  logic        stall, done, misalign, mem_we;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic [31:0] din;
    logic [31:0] addr;
    logic        we;
    int          stalls;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ram [0:63];
  logic [5:0]  ram_idx;

  pl_mem_access dut (
    .clock    (clock),
    .resetn   (resetn),
    .req      (req),
    .wr       (wr),
    .size     (size),
    .sext     (sext),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .done     (done),
    .misalign (misalign),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  always #5 clock = ~clock;

  assign ram_idx = mem_addr[7:2];

  always @(posedge clock) begin
    if (mem_we) ram[ram_idx] <= mem_din;
    mem_dout <= ram[ram_idx];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {28'b0, stall, done, misalign, mem_we};
  endfunction

  // Issue one access, hold it through any stall, then score the completion cycle.
  task automatic do_op(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input int n_stall,
                       input logic [31:0] e_rdata, input logic [31:0] e_din);
    exp_t e;
    int   stalls;
    logic got;
    e.tag = tag; e.rdata = e_rdata; e.din = e_din; e.we = w;
    e.addr = {a[31:2], 2'b00}; e.stalls = n_stall;
    sb.push_back(e);
    @(negedge clock);
    req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = wd;
    #2;
    stalls = 0;
    got    = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (stall) stalls++;
      @(negedge clock);
      #2;
    end
    e = sb.pop_front();
    check({e.tag, "_done"},   {31'b0, got}, 32'd1);
    check({e.tag, "_stalls"}, stalls, e.stalls);
    check({e.tag, "_rdata"},  rdata, e.rdata);
    check({e.tag, "_we"},     {31'b0, mem_we}, {31'b0, e.we});
    check({e.tag, "_din"},    mem_din, e.din);
    check({e.tag, "_maddr"},  mem_addr, e.addr);
    check({e.tag, "_stall0"}, {31'b0, stall}, 32'd0);
  endtask

  task automatic idle_check(input string tag, input logic [31:0] a);
    req  = 1'b0;
    addr = a;
    #2;
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_ctl"},   ctl(), 32'd0);
    check({tag, "_din"},   mem_din, 32'd0);
    check({tag, "_maddr"}, mem_addr, {a[31:2], 2'b00});
  endtask

  task automatic do_mis(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a);
    @(negedge clock);
    req = 1'b1; wr = w; size = sz; sext = 1'b0; addr = a; wdata = 32'hA5A5_A5A5;
    #2;
    check({tag, "_ctl"}, ctl(), 32'b0010);
    check({tag, "_din"}, mem_din, 32'd0);
    @(negedge clock);
    idle_check({tag, "_after"}, a);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[4]  = 32'h8899_AABB;
    ram[8]  = 32'h1122_3344;
    ram[12] = 32'hCAFE_F00D;
    ram[16] = 32'h0102_0304;
    resetn = 1'b0;
    req = 1'b1; wr = 1'b1; size = 2'b10; sext = 1'b1;
    addr = 32'h10; wdata = 32'hFFFF_FFFF;
    #12;
    check("rst_rdata", rdata, 32'd0);
    check("rst_ctl",   ctl(), 32'd0);
    check("rst_din",   mem_din, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    idle_check("idle0", 32'h17);

    do_op("ldb_s", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1, 32'hFFFF_FFAA, 32'h0);
    do_op("ldb_z", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1, 32'h0000_00AA, 32'h0);
    do_op("st_w",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 32'hDEAD_BEEF);
    do_op("ld_w",  1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 32'h0);
    do_op("st_h",  1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 2, 32'h0, 32'hBEEF_3344);
    do_op("ld_hs", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1, 32'hFFFF_BEEF, 32'h0);
    do_op("ld_hz", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1, 32'h0000_3344, 32'h0);
    @(negedge clock);
    idle_check("idle1", 32'h20);

    do_mis("mis_w", 1'b1, 2'b10, 32'h13);
    do_mis("mis_h", 1'b0, 2'b01, 32'h21);
    do_mis("mis_x", 1'b0, 2'b11, 32'h20);

    do_op("bb_st", 1'b1, 2'b00, 1'b0, 32'h30, 32'h1234_565A, 2, 32'h0, 32'hCAFE_F05A);
    do_op("bb_ld", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1, 32'hCAFE_F05A, 32'h0);
    @(negedge clock);
    idle_check("bb_idle", 32'h30);

    // Reset during the read half of a byte read-modify-write.
    @(negedge clock);
    req = 1'b1; wr = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h41; wdata = 32'h0000_00FF;
    #2;
    check("rmw_rst_stall0", {31'b0, stall}, 32'd1);
    @(negedge clock);
    #2;
    check("rmw_rst_stall1", {31'b0, stall}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("rmw_rst_rdata", rdata, 32'd0);
    check("rmw_rst_ctl",   ctl(), 32'd0);
    check("rmw_rst_din",   mem_din, 32'd0);
    check("rmw_rst_maddr", mem_addr, 32'd0);
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    idle_check("rmw_rel", 32'h47);
    @(negedge clock);
    idle_check("rmw_rel2", 32'h40);
    do_op("rmw_keep", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1, 32'h0102_0304, 32'h0);
    @(negedge clock);
    idle_check("end_idle", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pl_mem_access.md
PL_MEM_ACCESS -- requirements
Module: pl_mem_access

Interface
REQ-001 The block SHALL have these ports: clock, input, 1, the single clock; all state changes on the rising edge.
REQ-002 The block SHALL have these ports: resetn, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have these ports: req, input, 1, MEM-stage memory operation valid.
REQ-004 The block SHALL have these ports: wr, input, 1, 1 = store, 0 = load.
REQ-005 The block SHALL have these ports: size, input, 2, 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-006 The block SHALL have these ports: sext, input, 1, sign-extend sub-word loads when 1, zero-extend when 0.
REQ-007 The block SHALL have these ports: addr, input, 32, byte address; wdata, input, 32, store data in the low bits.
REQ-008 The block SHALL have these ports: rdata, output, 32, load result; stall, output, 1, pipeline hold.
REQ-009 The block SHALL have these ports: done, output, 1, one-cycle completion pulse; misalign, output, 1, one-cycle fault pulse.
REQ-010 The block SHALL have these ports: mem_addr, output, 32, RAM address; mem_din, output, 32, RAM write word; mem_we, output, 1, RAM write enable.
REQ-011 The block SHALL have this port: mem_dout, input, 32, RAM read word, valid the cycle after mem_addr is presented (synchronous read).

Function
REQ-012 The block SHALL be little-endian: byte lane = addr[1:0]; half lane = addr[1]; mem_addr SHALL be {addr[31:2],2'b00}.
REQ-013 The block SHALL implement the FSM states IDLE, LD, RMW_RD and RMW_WR; only IDLE accepts req.
REQ-014 The block SHALL, in IDLE with req=1, capture addr, wdata, size, sext and wr into internal registers at the edge leaving IDLE; later states use only captured values.
REQ-015 The block SHALL treat as misaligned: size=01 with addr[0]=1; size=10 with addr[1:0]!=00; size=11. In IDLE it SHALL assert misalign=1 for that cycle with mem_we=0, done=0 and stall=0, and stay in IDLE.
REQ-016 The block SHALL complete an aligned word store in IDLE in the same cycle: mem_we=1, mem_din=wdata, done=1, stall=0, staying in IDLE; zero stall cycles.
REQ-017 For a load, IDLE SHALL drive mem_addr with stall=1 and go to LD.
REQ-018 LD SHALL drive rdata = the extracted lane of mem_dout, sign- or zero-extended per sext (word ignores sext), with done=1 and stall=0, then return to IDLE; one stall cycle.
REQ-019 For a sub-word store, IDLE SHALL drive mem_addr with stall=1 and go to RMW_RD.
REQ-020 RMW_RD SHALL register mem_dout with the selected lane replaced by wdata[7:0] (byte) or wdata[15:0] (half), keep stall=1, and go to RMW_WR.
REQ-021 RMW_WR SHALL drive mem_we=1 and mem_din = the merged word, with done=1 and stall=0, then return to IDLE; two stall cycles.
REQ-022 Outside LD, rdata SHALL be 0; mem_we SHALL be 1 only in the cases of REQ-016 and REQ-021; mem_din SHALL be 0 when mem_we=0.
REQ-023 The block SHALL ignore req in non-IDLE states; upstream holds req stable while stall=1, and no second access is started from a held req.
REQ-024 In IDLE with req=0, all outputs SHALL be 0 except mem_addr, which SHALL follow the aligned addr.

Reset
REQ-025 While resetn=0, state SHALL be IDLE and rdata, stall, done, misalign, mem_we, mem_din and mem_addr SHALL all be 0, regardless of the other inputs.
REQ-026 Reset asserted in LD, RMW_RD or RMW_WR SHALL abort the operation; no write SHALL be issued for it after resetn rises, and the first cycle after release is IDLE.

Verification
REQ-027 Word store: addr=0x10, wdata=0xDEADBEEF, size=10 -> same cycle mem_we=1, mem_addr=0x10, mem_din=0xDEADBEEF, done=1, stall=0.
REQ-028 Signed byte load: RAM[0x10]=0x8899AABB, addr=0x11, size=00, sext=1 -> 1 stall cycle, then rdata=0xFFFFFFAA with done=1; with sext=0 -> rdata=0x000000AA.
REQ-029 Halfword RMW: RAM[0x20]=0x11223344, addr=0x22, size=01, wdata=0x0000BEEF -> stall for 2 cycles, then mem_we=1, mem_din=0xBEEF3344, done=1.
REQ-030 Misaligned: addr=0x13, size=10, wr=1 -> misalign=1 for 1 cycle, mem_we=0, done=0, stall=0.
REQ-031 Reset mid-RMW: resetn=0 during RMW_RD -> all outputs 0, RAM word unchanged, and IDLE follows release.
REQ-032 Back-to-back: a byte store to 0x30 followed immediately by a load of 0x30 -> the load returns the merged value, and each operation produces exactly one done pulse.
